// File: rtl/note_pkg.sv
// Shared definitions for the key-to-tone-enable path: play mode encodings,
// debounce counter sizing and a popcount reused by the mixer.
package note_pkg;

   localparam logic MODE_MOMENTARY = 1'b0;
   localparam logic MODE_TOGGLE    = 1'b1;

   // Widest vector popcount() accepts; key vectors are zero-extended to this.
   localparam int POP_W = 64;

   // Bits needed to count 0..cycles (cycles-1 is the largest value held).
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

   // Number of set bits in v.
   function automatic int unsigned popcount(input logic [POP_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_W; i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/note_enable_ctrl_if.sv
// Key/tone-enable bundle: raw switches and play mode in, per-note enables,
// note events, voice count and overflow out.
interface note_enable_ctrl_if #(
   parameter int N_KEYS = 8
);
   localparam int VCW = $clog2(N_KEYS + 1);

   logic [N_KEYS-1:0] sw;
   logic              mode;
   logic [N_KEYS-1:0] lfsr_en;
   logic [N_KEYS-1:0] note_on;
   logic [N_KEYS-1:0] note_off;
   logic [VCW-1:0]    voice_cnt;
   logic              overflow;

   // Board/stimulus side: drives switches and mode, observes the enables.
   modport master (
      output sw, mode,
      input  lfsr_en, note_on, note_off, voice_cnt, overflow
   );

   // Controller side.
   modport slave (
      input  sw, mode,
      output lfsr_en, note_on, note_off, voice_cnt, overflow
   );
endinterface

// File: rtl/note_enable_ctrl_debounce.sv
// One key channel: 2-flop synchroniser, persistence counter and the accepted
// (stable) level, plus one-cycle pulses coincident with each stable edge.
module key_debounce
   import note_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic stable,
   output logic press,
   output logic released
);
   localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_meta;
   logic          sync;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser for the asynchronous switch pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= sw_raw;
         sync      <= sync_meta;
      end
   end

   // Accept a new level only after it persists; any bounce back restarts.
   // press/released are registered together with stable so they mark the
   // exact cycle in which stable has just changed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable   <= 1'b0;
         cnt      <= '0;
         press    <= 1'b0;
         released <= 1'b0;
      end else begin
         press    <= 1'b0;
         released <= 1'b0;
         if (sync != stable) begin
            if (cnt == LAST) begin
               stable   <= sync;
               cnt      <= '0;
               press    <= sync;
               released <= ~sync;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/note_enable_ctrl.sv
// Maps N debounced key switches onto one-hot tone-generator enables, with
// momentary/toggle play modes, a lowest-index-wins polyphony cap and
// note on/off event pulses for the mixer.
module note_enable_ctrl
   import note_pkg::*;
#(
   parameter int N_KEYS          = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_VOICES      = 8
) (
   input logic             clk,
   input logic             rst_n,
   note_enable_ctrl_if.slave bus
);
   localparam int VCW = $clog2(N_KEYS + 1);

   logic [N_KEYS-1:0] stable;
   logic [N_KEYS-1:0] press;
   // Release events are not needed here: toggle latches flip on press only.
   logic [N_KEYS-1:0] release_unused;
   logic [N_KEYS-1:0] latch;
   logic [N_KEYS-1:0] req;
   logic [N_KEYS-1:0] grant;
   int                taken;

   logic [N_KEYS-1:0] en_q;
   logic [N_KEYS-1:0] on_q;
   logic [N_KEYS-1:0] off_q;
   logic [VCW-1:0]    vcnt_q;
   logic              ovf_q;

   genvar g;
   generate
      for (g = 0; g < N_KEYS; g++) begin : g_key
         key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_key (
            .clk      (clk),
            .rst_n    (rst_n),
            .sw_raw   (bus.sw[g]),
            .stable   (stable[g]),
            .press    (press[g]),
            .released (release_unused[g])
         );
      end
   endgenerate

   // Toggle latches flip on each press; leaving toggle mode clears them so
   // re-entering toggle mode always starts with every note off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latch <= '0;
      end else if (bus.mode == MODE_TOGGLE) begin
         latch <= latch ^ press;
      end else begin
         latch <= '0;
      end
   end

   // Request vector; in toggle mode use the post-press latch value so both
   // play modes reach the output register on the same edge.
   always_comb begin
      req = stable;
      if (bus.mode == MODE_TOGGLE) begin
         req = latch ^ press;
      end
   end

   // Grant the lowest-indexed MAX_VOICES requests, regardless of which
   // notes are already sounding.
   always_comb begin
      grant = '0;
      taken = 0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (req[i] && (taken < MAX_VOICES)) begin
            grant[i] = 1'b1;
            taken++;
         end
      end
   end

   // Output register: enables, edge events, voice count and overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= '0;
         on_q   <= '0;
         off_q  <= '0;
         vcnt_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         en_q   <= grant;
         on_q   <= grant & ~en_q;
         off_q  <= ~grant & en_q;
         vcnt_q <= VCW'(popcount(POP_W'(grant)));
         ovf_q  <= popcount(POP_W'(req)) > 32'(MAX_VOICES);
      end
   end

   assign bus.lfsr_en   = en_q;
   assign bus.note_on   = on_q;
   assign bus.note_off  = off_q;
   assign bus.voice_cnt = vcnt_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: doc/note_enable_ctrl.md
Name: note_enable_ctrl

Overview:
- Parametrised successor of the switch-to-LFSR-enable mapping. Takes N raw key switches and drives N one-hot tone-generator enables.
- Adds per-channel synchronisation, debounce, momentary/toggle play modes and a polyphony cap.
- Sits between board switch pins and the per-note LFSR/tone generators. Also reports note-on/off events and the active voice count to the mixer.

Parameters:
- N_KEYS, 8, number of key channels (>=1).
- DEBOUNCE_CYCLES, 4, consecutive cycles a new synced level must persist before it is accepted (>=1).
- MAX_VOICES, 8, maximum simultaneous enables (1..N_KEYS; equal to N_KEYS means no cap).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  N_KEYS  raw, asynchronous key switches; bit i is key i.
- mode  input  1  0 = momentary (note plays while held), 1 = toggle (each press flips latch); synchronous to clk.
- lfsr_en  output  N_KEYS  registered enable per tone generator.
- note_on  output  N_KEYS  one-cycle pulse when lfsr_en[i] rises.
- note_off  output  N_KEYS  one-cycle pulse when lfsr_en[i] falls.
- voice_cnt  output  $clog2(N_KEYS+1)  popcount of lfsr_en, registered with it.
- overflow  output  1  high while requested notes exceed MAX_VOICES.

Behaviour:
- Decided interface rule: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset (rst_n low, any time): sync flops, stable, counters, toggle latches, lfsr_en, note_on, note_off, voice_cnt and overflow all go to 0 immediately. A release mid-debounce leaves no partial count.
- Synchroniser: 2-flop chain per bit, giving sync[i].
- Debounce, per channel:
  - If sync != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - Else if sync != stable: cnt++.
  - Else: cnt <= 0. Any bounce back restarts the count.
- Events:
  - press[i] = stable rises this cycle.
  - release[i] = stable falls this cycle.
- Request vector:
  - mode=0: req[i] = stable[i]; toggle latches are held at 0.
  - mode=1: latch[i] flips on press[i]; release is ignored; req[i] = latch[i].
  - Switching 1->0 clears all latches. Switching 0->1 therefore always starts with all toggles off.
- Polyphony allocation (combinational):
  - grant = the lowest-indexed MAX_VOICES set bits of req.
  - Lower index wins, even over notes already sounding. A newly pressed lower key can steal a voice, which produces simultaneous note_on and note_off pulses on different bits.
- Output register, every cycle:
  - lfsr_en <= grant.
  - note_on <= grant & ~lfsr_en.
  - note_off <= ~grant & lfsr_en.
  - voice_cnt <= popcount(grant).
  - overflow <= popcount(req) > MAX_VOICES.
- Latency: call the first clk edge that samples a new sw level edge 1. lfsr_en, note_on and note_off update on edge DEBOUNCE_CYCLES+3 (edge 7 at default), provided sw is held stable throughout.
- Pulses shorter than DEBOUNCE_CYCLES synced cycles produce no output change.
- Simultaneous presses on several keys in one cycle are handled in parallel; allocation applies the cap in the same cycle.
- Counter width: $clog2(DEBOUNCE_CYCLES+1); no wrap is possible.

Decomposition:
- Shared package note_pkg:
  - MODE_MOMENTARY = 1'b0, MODE_TOGGLE = 1'b1.
  - Function for counter width.
  - Function for popcount (reused by the mixer).
- Sub-module key_debounce: one channel with 2-flop sync, counter and stable flop; outputs stable, press, release. Instantiated N_KEYS times via generate.
- Top level holds the toggle latches, allocator and output register.

Test Plan (N_KEYS=8, DEBOUNCE_CYCLES=4, MAX_VOICES=3 unless noted):
- Basic press, mode=0: sw=8'h04 held from edge 1 -> lfsr_en=8'h04, note_on=8'h04 (for one cycle) and voice_cnt=1 at edge 7. Release -> note_off=8'h04 and lfsr_en=0 at edge 7 after the release.
- Bounce: sw[0] toggles 1,0,1,0 each cycle for 6 cycles then returns to 0 -> lfsr_en stays 0, no pulses. Same bounce then held high -> lfsr_en[0]=1 exactly 7 edges after the final rise.
- Toggle mode: mode=1; press then release sw[5] -> lfsr_en[5]=1 and stays 1. Second press -> lfsr_en[5]=0 with note_off[5]. Set mode=0 -> latch clears and lfsr_en follows sw only.
- Polyphony cap: sw=8'hF0 -> lfsr_en=8'h70, voice_cnt=3, overflow=1. Then add sw[1] -> lfsr_en=8'h32, note_on=8'h02 and note_off=8'h40 in the same cycle.
- Async reset mid-operation: sw=8'hFF with lfsr_en=8'h07; assert rst_n low mid-cycle -> all outputs 0 without waiting for a clock edge. Release reset with sw still 8'hFF -> lfsr_en=8'h07 at edge 7 after release.
- No-cap config (MAX_VOICES=8): sw=8'hFF -> lfsr_en=8'hFF, voice_cnt=8, overflow=0.
